// File: rtl/led_dimmer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_dimmer_pkg
// Description : Config register layout, reset constants and helpers for led_dimmer.
// Revision    : 1.0 - initial release
// ============================================================================
package led_dimmer_pkg;

    localparam int PRESCALE_DEFAULT = 4;

    localparam int BRIGHT_LSB   = 0;
    localparam int BRIGHT_W     = 8;
    localparam int RATE_LSB     = 8;
    localparam int RATE_W       = 4;
    localparam int BLINK_EN_BIT = 12;
    localparam int CFG_W        = 13;

    localparam logic [15:0] CFG_RESET = 16'h00FF;

    typedef struct packed {
        logic                blink_en;
        logic [RATE_W-1:0]   blink_rate;
        logic [BRIGHT_W-1:0] brightness;
    } cfg_t;

    localparam cfg_t CFG_RESET_C = cfg_t'(CFG_RESET[CFG_W-1:0]);

    function automatic logic [15:0] cfg_word(input cfg_t c);
        return {{(16-CFG_W){1'b0}}, c};
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_timebase
// Description : Prescaler plus free-running 8-bit PWM counter with period-start strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_timebase #(
    parameter int PRESCALE = 4
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] pwmCnt,
    output logic       periodStart
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc;
    logic          tick;

    assign tick        = (presc == PW'(PRESCALE - 1));
    assign periodStart = tick && (pwmCnt == 8'hFF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc  <= '0;
            pwmCnt <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                pwmCnt <= pwmCnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_dimmer.sv
`default_nettype none
// ============================================================================
// Module      : led_dimmer
// Description : PWM dimmer/blinker for an 8-bit LED pattern with a bus config register.
//               Blink logic is built only when LED_DIMMER_BLINK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module led_dimmer
    import led_dimmer_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  ledIn,
    input  logic [15:0] dataIn,
    input  logic        Write,
    input  logic        Read,
    output logic [15:0] dataOut,
    output logic        Ack,
    output logic [7:0]  ledOut
);

    cfg_t       cfg;
    cfg_t       wr_cfg;
    logic [7:0] active_bright;
    logic [7:0] pwm_cnt;
    logic       period_start;
    logic       blink_phase;
    logic       on;

    led_pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clock       (clock),
        .reset       (reset),
        .pwmCnt      (pwm_cnt),
        .periodStart (period_start)
    );

`ifdef LED_DIMMER_BLINK_EN
    logic       unused_data;
    logic [7:0] period_cnt;

    assign wr_cfg      = cfg_t'(dataIn[CFG_W-1:0]);
    assign unused_data = ^dataIn[15:CFG_W];

    // Blink fields are only sampled at period start, i.e. exactly when they
    // would enter the active shadow, so cfg itself serves as that shadow here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_cnt  <= '0;
            blink_phase <= 1'b1;
        end else if (period_start) begin
            if (!cfg.blink_en) begin
                blink_phase <= 1'b1;
                period_cnt  <= period_cnt + 8'd1;
            end else if (period_cnt == {cfg.blink_rate, 4'hF}) begin
                blink_phase <= ~blink_phase;
                period_cnt  <= '0;
            end else begin
                period_cnt  <= period_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_data;

    assign wr_cfg      = '{blink_en: 1'b0, blink_rate: '0, brightness: dataIn[BRIGHT_W-1:0]};
    assign unused_data = ^dataIn[15:RATE_LSB];
    assign blink_phase = 1'b1;
`endif

    // 0xFF must force on because pwm_cnt never exceeds 255.
    always_comb begin
        on = (active_bright == 8'hFF) || (pwm_cnt < active_bright);
    end

    assign dataOut = cfg_word(cfg);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg           <= CFG_RESET_C;
            active_bright <= CFG_RESET_C.brightness;
            Ack           <= 1'b0;
            ledOut        <= 8'h00;
        end else begin
            Ack    <= Write | Read;
            ledOut <= ledIn & {8{on & blink_phase}};
            if (Write) begin
                cfg <= wr_cfg;
            end
            if (period_start) begin
                active_bright <= cfg.brightness;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_dimmer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_dimmer
// Description : Scoreboard bench for led_dimmer (PRESCALE=1), directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_led_dimmer;

    logic        clock  = 1'b0;
    logic        reset  = 1'b1;
    logic [7:0]  ledIn  = 8'h00;
    logic [15:0] dataIn = 16'h0000;
    logic        Write  = 1'b0;
    logic        Read   = 1'b0;
    logic [15:0] dataOut;
    logic        Ack;
    logic [7:0]  ledOut;

    always #5 clock = ~clock;

    led_dimmer #(
        .PRESCALE (1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ledIn   (ledIn),
        .dataIn  (dataIn),
        .Write   (Write),
        .Read    (Read),
        .dataOut (dataOut),
        .Ack     (Ack),
        .ledOut  (ledOut)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // kind: 0 = ledOut, 1 = dataOut, 2 = Ack
    task automatic expect_at(input int at, input int kind, input logic [15:0] val, input string name);
        exp_t e;
        int   pos;
        e.cyc  = at;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        pos = sbq.size();
        while (pos > 0 && sbq[pos-1].cyc > at) pos--;
        sbq.insert(pos, e);
    endtask

    always @(negedge clock) begin
        exp_t        e;
        logic [15:0] act;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            case (e.kind)
                0:       act = {8'h00, ledOut};
                1:       act = dataOut;
                default: act = {15'b0, Ack};
            endcase
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: stale check for cycle %0d at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                bad++;
                $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, act, e.val);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic step_to(input int target);
        if (target > cyc) step(target - cyc);
    endtask

    task automatic wr(input logic [15:0] d);
        dataIn = d;
        Write  = 1'b1;
        step(1);
        Write  = 1'b0;
    endtask

    initial begin
        int r;
        int c;
        int s;

        // Reset values while reset held
        step(2);
        expect_at(cyc, 0, 16'h0000, "rst_led");
        expect_at(cyc, 1, 16'h00FF, "rst_dout");
        expect_at(cyc, 2, 16'h0000, "rst_ack");
        step(1);

        // Release: pwmCnt is 0 at cycle r, n at cycle r+n
        ledIn = 8'hA5;
        reset = 1'b0;
        r = cyc;
        expect_at(r,     1, 16'h00FF, "rel_dout");
        expect_at(r + 1, 0, 16'h00A5, "rel_led");
        expect_at(r + 1, 2, 16'h0000, "rel_ack");
        step(1);

        // Write held 3 cycles, then Read, then Write+Read
        c = cyc;
        dataIn = 16'h0040;
        Write  = 1'b1;
        expect_at(c + 1, 2, 16'h0001, "wr_ack1");
        expect_at(c + 2, 2, 16'h0001, "wr_ack2");
        expect_at(c + 3, 2, 16'h0001, "wr_ack3");
        expect_at(c + 4, 2, 16'h0000, "wr_ack_drop");
        expect_at(c + 1, 1, 16'h0040, "wr_dout");
        step(3);
        Write = 1'b0;
        ledIn = 8'hFF;
        step(1);
        Read = 1'b1;
        expect_at(c + 5, 2, 16'h0001, "rd_ack1");
        expect_at(c + 6, 2, 16'h0001, "rd_ack2");
        expect_at(c + 5, 1, 16'h0040, "rd_dout");
        step(2);
        Read = 1'b0;
        expect_at(c + 7, 2, 16'h0000, "rd_ack_drop");
        step(1);
        dataIn = 16'h0040;
        Write  = 1'b1;
        Read   = 1'b1;
        expect_at(c + 8, 2, 16'h0001, "wrrd_ack");
        expect_at(c + 9, 2, 16'h0000, "wrrd_ack_drop");
        expect_at(c + 8, 1, 16'h0040, "wrrd_dout");
        step(1);
        Write = 1'b0;
        Read  = 1'b0;

        // Brightness 0x40 active from period start at r+256: 64 on, 192 off
        for (int n = 256; n < 512; n++)
            expect_at(r + n + 1, 0, (n - 256 < 64) ? 16'h00FF : 16'h0000, "pwm40");

        // Write 0x0000 at pwmCnt 8 of third period
        step_to(r + 520);
        expect_at(r + 521, 1, 16'h0000, "w0_dout");
        expect_at(r + 521, 2, 16'h0001, "w0_ack");
        expect_at(r + 522, 2, 16'h0000, "w0_ack_drop");
        wr(16'h0000);
        for (int n = 521; n < 768; n++)
            expect_at(r + n + 1, 0, (n - 512 < 64) ? 16'h00FF : 16'h0000, "w0_hold");
        for (int n = 768; n < 1024; n++)
            expect_at(r + n + 1, 0, 16'h0000, "w0_off");

        // Full brightness, then a pending config, then reset at pwmCnt 0x80
        step_to(r + 1030);
        wr(16'h00FF);
        step_to(r + 1300);
        wr(16'h0033);
        expect_at(cyc, 1, 16'h0033, "pre_rst_dout");
        expect_at(r + 1407, 0, 16'h00FF, "pre_rst_led");
        step_to(r + 1408);
        reset  = 1'b1;
        Write  = 1'b1;
        dataIn = 16'h1234;
        expect_at(r + 1408, 0, 16'h0000, "async_rst_led");
        expect_at(r + 1408, 2, 16'h0000, "async_rst_ack");
        expect_at(r + 1408, 1, 16'h00FF, "async_rst_dout");
        expect_at(r + 1409, 2, 16'h0000, "rst_wr_ack");
        expect_at(r + 1409, 1, 16'h00FF, "rst_wr_dout");
        step(2);
        Write = 1'b0;
        reset = 1'b0;
        s = cyc;
        expect_at(s + 1, 0, 16'h00FF, "rel2_led");
        expect_at(s + 1, 2, 16'h0000, "rel2_ack");
        step(1);
        wr(16'h0010);
        expect_at(s + 257, 0, 16'h00FF, "restart_first");
        expect_at(s + 272, 0, 16'h00FF, "restart_last_on");
        expect_at(s + 273, 0, 16'h0000, "restart_first_off");
        expect_at(s + 512, 0, 16'h0000, "restart_end");

`ifdef LED_DIMMER_BLINK_EN
        step_to(s + 300);
        wr(16'h10FF);
        expect_at(cyc, 1, 16'h10FF, "blink_dout");
        expect_at(s + 4096,  0, 16'h00FF, "blink_on0");
        expect_at(s + 4097,  0, 16'h0000, "blink_off0");
        expect_at(s + 6000,  0, 16'h0000, "blink_off_mid");
        expect_at(s + 8192,  0, 16'h0000, "blink_off1");
        expect_at(s + 8193,  0, 16'h00FF, "blink_on1");
        expect_at(s + 12288, 0, 16'h00FF, "blink_on2");
        expect_at(s + 12289, 0, 16'h0000, "blink_off2");
`else
        step_to(s + 300);
        wr(16'h10FF);
        expect_at(cyc, 1, 16'h00FF, "noblink_dout");
        expect_at(s + 1000, 0, 16'h00FF, "noblink_led");
`endif

        for (int i = 0; i < 20000 && sbq.size() > 0; i++) step(1);
        if (sbq.size() > 0) begin
            bad += sbq.size();
            $display("FAIL drain: %0d checks left, expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
